// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
// Holds the scanner FSM state encoding, the one-hot row drive constants,
// the (row, column) -> hex key map and small one-hot helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_0 = 4'b0001;
    localparam logic [3:0] ROW_1 = 4'b0010;
    localparam logic [3:0] ROW_2 = 4'b0100;
    localparam logic [3:0] ROW_3 = 4'b1000;

    // Row index to one-hot row drive pattern.
    function automatic logic [3:0] row_onehot(input logic [1:0] idx);
        logic [3:0] r;
        case (idx)
            2'd0:    r = ROW_0;
            2'd1:    r = ROW_1;
            2'd2:    r = ROW_2;
            2'd3:    r = ROW_3;
            default: r = ROW_0;
        endcase
        return r;
    endfunction

    // Physical key layout: r0:1 2 3 A, r1:4 5 6 B, r2:7 8 9 C, r3:E 0 F D.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // True when exactly one bit of the column vector is set.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

    // Index of the set bit of a one-hot column vector.
    function automatic logic [1:0] col_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: 4-bit two-flop synchronizer bringing the raw keypad column levels
// into the clk domain. Both stages clear on the synchronous reset.
module sync2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_r;
    logic [3:0] sync_r;

    // Two-stage capture of the asynchronous column levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 4'h0;
            sync_r <= 4'h0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with press/release debounce.
// Rows are driven one-hot in turn; a single active column at the end of a
// row's dwell starts a debounce, an accepted key pulses key_valid once and
// key_held stays high until the release has been debounced.
// Optional feature macro: KEYPAD_SCAN_TWO_DIGIT_EN keeps the previously
// accepted code on prev_code; when undefined prev_code is constant zero.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] prev_code
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);

    logic [3:0]    scol_s;

    state_t        state_r;
    state_t        state_n_s;
    logic [DW-1:0] dwell_r;
    logic [DW-1:0] dwell_n_s;
    logic [1:0]    row_idx_r;
    logic [1:0]    row_idx_n_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n_s;
    logic [3:0]    col_r;
    logic [3:0]    col_n_s;
    logic [3:0]    code_n_s;
    logic          valid_s;
    logic          held_n_s;

    logic [3:0]    rows_r;
    logic [3:0]    key_code_r;
    logic          key_valid_r;
    logic          key_held_r;

    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (cols),
        .q     (scol_s)
    );

    // Next-state, counter and key-capture decisions of the scanner FSM.
    always_comb begin
        state_n_s   = state_r;
        dwell_n_s   = dwell_r;
        row_idx_n_s = row_idx_r;
        cnt_n_s     = cnt_r;
        col_n_s     = col_r;
        code_n_s    = key_code_r;
        valid_s     = 1'b0;
        case (state_r)
            SCAN: begin
                if (dwell_r == DWELL_LAST) begin
                    dwell_n_s = {DW{1'b0}};
                    if (is_onehot(scol_s)) begin
                        // Rows stay frozen on this row while debouncing.
                        col_n_s   = scol_s;
                        cnt_n_s   = {CW{1'b0}};
                        state_n_s = DEBOUNCE;
                    end else begin
                        row_idx_n_s = row_idx_r + 2'd1;
                    end
                end else begin
                    dwell_n_s = dwell_r + DWELL_ONE;
                end
            end
            DEBOUNCE: begin
                if (scol_s == col_r) begin
                    if (cnt_r == DB_LAST) begin
                        state_n_s = PRESSED;
                        code_n_s  = key_map(row_idx_r, col_index(col_r));
                        valid_s   = 1'b1;
                    end else begin
                        cnt_n_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    // Bounce or glitch: drop it and carry on with the next row.
                    state_n_s   = SCAN;
                    dwell_n_s   = {DW{1'b0}};
                    row_idx_n_s = row_idx_r + 2'd1;
                end
            end
            PRESSED: begin
                if ((scol_s & col_r) == 4'h0) begin
                    state_n_s = RELEASE;
                    cnt_n_s   = {CW{1'b0}};
                end else begin
                    state_n_s = PRESSED;
                end
            end
            RELEASE: begin
                if ((scol_s & col_r) != 4'h0) begin
                    state_n_s = PRESSED;
                end else if (cnt_r == DB_LAST) begin
                    state_n_s   = SCAN;
                    dwell_n_s   = {DW{1'b0}};
                    row_idx_n_s = row_idx_r + 2'd1;
                end else begin
                    cnt_n_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_n_s   = SCAN;
                dwell_n_s   = {DW{1'b0}};
                row_idx_n_s = 2'd0;
                cnt_n_s     = {CW{1'b0}};
            end
        endcase
        held_n_s = (state_n_s == PRESSED) || (state_n_s == RELEASE);
    end

    // FSM state, scan position, debounce counter and latched column.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= SCAN;
            dwell_r   <= {DW{1'b0}};
            row_idx_r <= 2'd0;
            cnt_r     <= {CW{1'b0}};
            col_r     <= 4'h0;
        end else begin
            state_r   <= state_n_s;
            dwell_r   <= dwell_n_s;
            row_idx_r <= row_idx_n_s;
            cnt_r     <= cnt_n_s;
            col_r     <= col_n_s;
        end
    end

    // Registered outputs: row drive, accepted code, valid pulse, held flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_r      <= ROW_0;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            rows_r      <= row_onehot(row_idx_n_s);
            key_code_r  <= code_n_s;
            key_valid_r <= valid_s;
            key_held_r  <= held_n_s;
        end
    end

`ifdef KEYPAD_SCAN_TWO_DIGIT_EN
    logic [3:0] prev_code_r;

    // Shift the outgoing code into prev_code whenever a new key is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_code_r <= 4'h0;
        end else if (valid_s) begin
            prev_code_r <= key_code_r;
        end else begin
            prev_code_r <= prev_code_r;
        end
    end

    assign prev_code = prev_code_r;
`else
    assign prev_code = 4'h0;
`endif

    assign rows      = rows_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed self-checking bench for keypad_scan_ctrl
// (SCAN_DIV=4, DEBOUNCE_CYCLES=8). A small keypad model returns the pressed
// key's column only while its row is driven; force_en overrides the columns
// for glitch, bounce and multi-key patterns. Outputs are sampled on negedge.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] prev_code;

    logic       key_down;
    logic [1:0] key_row;
    logic [3:0] key_col;
    logic       force_en;
    logic [3:0] force_cols;

    int checks;
    int errors;
    int valid_count;

    keypad_scan_ctrl #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .prev_code (prev_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model with an override path.
    always_comb begin
        if (force_en) cols = force_cols;
        else if (key_down && rows[key_row]) cols = key_col;
        else cols = 4'h0;
    end

    // Count key_valid pulses shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (key_valid === 1'b1) valid_count++;
    end

    task automatic do_reset();
        @(negedge clk);
        force_en = 1'b0;
        key_down = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit found);
        int v0;
        v0 = valid_count;
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (valid_count != v0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_release(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rows !== 4'b0001) begin errors++; $display("FAIL reset_rows: got %b expected 0001", rows); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", key_code); end
        checks++; if (prev_code !== 4'h0) begin errors++; $display("FAIL reset_prev: got %h expected 0", prev_code); end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] exp;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            exp = 4'b0001 << ((k / 4) % 4);
            checks++; if (rows !== exp) begin errors++; $display("FAIL scan_rows k=%0d: got %b expected %b", k, rows, exp); end
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL scan_valid k=%0d: got %b expected 0", k, key_valid); end
        end
    endtask

    task automatic test_key5();
        int v0;
        int n;
        do_reset();
        key_row = 2'd1; key_col = 4'b0010; key_down = 1'b1;
        v0 = valid_count;
        repeat (40) @(negedge clk);
        checks++; if (valid_count - v0 !== 1) begin errors++; $display("FAIL key5_pulses: got %0d expected 1", valid_count - v0); end
        checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL key5_code: got %h expected 5", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL key5_held: got %b expected 1", key_held); end
        checks++; if (rows !== 4'b0010) begin errors++; $display("FAIL key5_frozen: got %b expected 0010", rows); end
        key_down = 1'b0;
        wait_release(30, n);
        checks++; if (n !== 11) begin errors++; $display("FAIL key5_release_cycles: got %0d expected 11", n); end
        checks++; if (rows !== 4'b0100) begin errors++; $display("FAIL key5_next_row: got %b expected 0100", rows); end
        checks++; if (valid_count - v0 !== 1) begin errors++; $display("FAIL key5_pulses_after: got %0d expected 1", valid_count - v0); end
    endtask

    task automatic test_pulse();
        int v0;
        do_reset();
        v0 = valid_count;
        @(negedge clk);
        force_en = 1'b1; force_cols = 4'b0001;
        repeat (3) @(negedge clk);
        checks++; if (rows !== 4'b0001) begin errors++; $display("FAIL pulse_frozen_n4: got %b expected 0001", rows); end
        force_cols = 4'h0;
        repeat (2) @(negedge clk);
        checks++; if (rows !== 4'b0001) begin errors++; $display("FAIL pulse_frozen_n6: got %b expected 0001", rows); end
        @(negedge clk);
        checks++; if (rows !== 4'b0010) begin errors++; $display("FAIL pulse_next_row: got %b expected 0010", rows); end
        repeat (4) @(negedge clk);
        checks++; if (rows !== 4'b0100) begin errors++; $display("FAIL pulse_dwell: got %b expected 0100", rows); end
        repeat (10) @(negedge clk);
        checks++; if (valid_count !== v0) begin errors++; $display("FAIL pulse_no_valid: got %0d pulses expected 0", valid_count - v0); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL pulse_held: got %b expected 0", key_held); end
        force_en = 1'b0;
    endtask

    task automatic test_release_bounce();
        bit found;
        int v0;
        int drop;
        do_reset();
        key_row = 2'd3; key_col = 4'b1000; key_down = 1'b1;
        wait_valid(60, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL bounce_press_timeout: got no pulse expected pulse"); end
        checks++; if (key_code !== 4'hD) begin errors++; $display("FAIL bounce_code: got %h expected d", key_code); end
        repeat (5) @(negedge clk);
        v0 = valid_count;
        force_en = 1'b1; force_cols = 4'h0;
        drop = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (key_held === 1'b0 && drop == 0) drop = k;
            if (k == 3) force_cols = 4'b1000;
            if (k == 5) force_cols = 4'h0;
        end
        checks++; if (drop !== 16) begin errors++; $display("FAIL bounce_release_cycles: got %0d expected 16", drop); end
        checks++; if (valid_count !== v0) begin errors++; $display("FAIL bounce_extra_valid: got %0d expected 0", valid_count - v0); end
        checks++; if (key_code !== 4'hD) begin errors++; $display("FAIL bounce_code_kept: got %h expected d", key_code); end
        force_en = 1'b0; key_down = 1'b0;
    endtask

    task automatic test_two_cols();
        logic [3:0] exp;
        int v0;
        do_reset();
        force_en = 1'b1; force_cols = 4'b0011;
        v0 = valid_count;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            exp = 4'b0001 << ((k / 4) % 4);
            checks++; if (rows !== exp) begin errors++; $display("FAIL twocol_rows k=%0d: got %b expected %b", k, rows, exp); end
        end
        checks++; if (valid_count !== v0) begin errors++; $display("FAIL twocol_valid: got %0d expected 0", valid_count - v0); end
        force_en = 1'b0;
    endtask

    task automatic test_two_digit();
        bit found;
        int n;
        logic [3:0] exp_prev;
`ifdef KEYPAD_SCAN_TWO_DIGIT_EN
        exp_prev = 4'h7;
`else
        exp_prev = 4'h0;
`endif
        do_reset();
        key_row = 2'd2; key_col = 4'b0001; key_down = 1'b1;
        wait_valid(60, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL digit7_timeout: got no pulse expected pulse"); end
        checks++; if (key_code !== 4'h7) begin errors++; $display("FAIL digit7_code: got %h expected 7", key_code); end
        key_down = 1'b0;
        wait_release(40, n);
        key_row = 2'd0; key_col = 4'b0100; key_down = 1'b1;
        wait_valid(80, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL digit3_timeout: got no pulse expected pulse"); end
        checks++; if (key_code !== 4'h3) begin errors++; $display("FAIL digit3_code: got %h expected 3", key_code); end
        checks++; if (prev_code !== exp_prev) begin errors++; $display("FAIL digit_prev: got %h expected %h", prev_code, exp_prev); end
        key_down = 1'b0;
        wait_release(40, n);
    endtask

    task automatic test_reset_mid();
        bit found;
        int v0;
        do_reset();
        v0 = valid_count;
        @(negedge clk);
        force_en = 1'b1; force_cols = 4'b0001;
        repeat (5) @(negedge clk);
        reset = 1'b1; force_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rows !== 4'b0001) begin errors++; $display("FAIL rstdb_rows: got %b expected 0001", rows); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (rows !== 4'b0010) begin errors++; $display("FAIL rstdb_resume: got %b expected 0010", rows); end
        repeat (20) @(negedge clk);
        checks++; if (valid_count !== v0) begin errors++; $display("FAIL rstdb_valid: got %0d expected 0", valid_count - v0); end
        key_row = 2'd1; key_col = 4'b0100; key_down = 1'b1;
        wait_valid(60, found);
        checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL rstpr_code: got %h expected 6", key_code); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rstpr_held: got %b expected 0", key_held); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rstpr_code_clr: got %h expected 0", key_code); end
        checks++; if (rows !== 4'b0001) begin errors++; $display("FAIL rstpr_rows: got %b expected 0001", rows); end
        key_down = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; valid_count = 0;
        reset = 1'b1; key_down = 1'b0; key_row = 2'd0; key_col = 4'h0;
        force_en = 1'b0; force_cols = 4'h0;
        test_reset();
        test_scan();
        test_key5();
        test_pulse();
        test_release_bounce();
        test_two_cols();
        test_two_digit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
